// File: rtl/fwd_clk_pkg.sv
// Shared definitions for the forwarded-clock burst controller.
package fwd_clk_pkg;

    localparam int DEF_DIV_W = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        RUN   = 2'd2,
        TRAIL = 2'd3
    } state_t;

endpackage

// File: rtl/fwd_clk_half_timer.sv
// Loadable half-period down-counter; expire is high in the last cycle of a half period.
module fwd_clk_half_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             expire
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/fwd_clk_burst_ctrl.sv
// Forwarded-clock burst sequencer: LEAD low, D-high/D-low pulses, TRAIL low, done pulse.
import fwd_clk_pkg::*;

module fwd_clk_burst_ctrl #(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_cont,
    input  logic             burst_req,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             abort,
    output logic             burst_ack,
    output logic             busy,
    output logic             done,
    output logic             fwd_clk_o,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] edge_cnt
);

    state_t           state, state_n;
    logic [DIV_W-1:0] div_q;
    logic             cont_q;
    logic [CNT_W-1:0] rem_q;
    logic             abort_pend, pend_n;
    logic             clk_n, rise_n, fall_n, ack_n, busy_n, done_n;
    logic             load, latch, cnt_clr, cnt_inc, expire;
    logic [DIV_W-1:0] load_val;

    // Reload value of the half-period timer: D-1, with a zero divider acting as 1.
    function automatic logic [DIV_W-1:0] half_last(input logic [DIV_W-1:0] div);
        return (div == '0) ? '0 : div - 1'b1;
    endfunction

    fwd_clk_half_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    always_comb begin
        state_n  = state;
        clk_n    = fwd_clk_o;
        rise_n   = 1'b0;
        fall_n   = 1'b0;
        ack_n    = 1'b0;
        busy_n   = busy;
        done_n   = 1'b0;
        pend_n   = abort_pend;
        load     = 1'b0;
        load_val = half_last(div_q);
        latch    = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (burst_req) begin
                    state_n  = LEAD;
                    ack_n    = 1'b1;
                    busy_n   = 1'b1;
                    latch    = 1'b1;
                    cnt_clr  = 1'b1;
                    load     = 1'b1;
                    load_val = half_last(cfg_div);
                    pend_n   = 1'b0;
                end
            end
            LEAD: begin
                if (abort) begin
                    state_n = TRAIL;
                    load    = 1'b1;
                end else if (expire) begin
                    load = 1'b1;
                    if (cont_q || rem_q != '0) begin
                        state_n = RUN;
                        clk_n   = 1'b1;
                        rise_n  = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        state_n = TRAIL;
                    end
                end
            end
            RUN: begin
                // An abort seen anywhere in a pulse ends the burst after that pulse's low half.
                pend_n = abort_pend | abort;
                if (expire) begin
                    load = 1'b1;
                    if (fwd_clk_o) begin
                        clk_n  = 1'b0;
                        fall_n = 1'b1;
                    end else if (abort_pend || abort || (!cont_q && rem_q == '0)) begin
                        state_n = TRAIL;
                    end else begin
                        clk_n   = 1'b1;
                        rise_n  = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (expire) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            abort_pend <= 1'b0;
            burst_ack  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fwd_clk_o  <= 1'b0;
            rise_stb   <= 1'b0;
            fall_stb   <= 1'b0;
            edge_cnt   <= '0;
        end else begin
            state      <= state_n;
            abort_pend <= pend_n;
            burst_ack  <= ack_n;
            busy       <= busy_n;
            done       <= done_n;
            fwd_clk_o  <= clk_n;
            rise_stb   <= rise_n;
            fall_stb   <= fall_n;
            if (cnt_clr) begin
                edge_cnt <= '0;
            end else if (cnt_inc && edge_cnt != '1) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

    // Burst configuration is captured at ack and frozen for the whole burst.
    always_ff @(posedge clk) begin
        if (latch) begin
            div_q  <= cfg_div;
            cont_q <= cfg_cont;
            rem_q  <= burst_len;
        end else if (cnt_inc && rem_q != '0) begin
            rem_q <= rem_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_clk_burst_ctrl.sv
// Directed bench for fwd_clk_burst_ctrl; per-cycle traces are captured as bit masks (bit i = cycle i).
module tb_fwd_clk_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_div;
    logic        cfg_cont;
    logic        burst_req;
    logic [15:0] burst_len;
    logic        abort;
    logic        burst_ack, busy, done, fwd_clk_o, rise_stb, fall_stb;
    logic [15:0] edge_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] cap_fw, cap_ri, cap_fa, cap_ack, cap_busy, cap_done;
    logic [31:0] acc;
    int          rel_at, abort_at, chg_at;
    logic [7:0]  chg_div;
    logic [15:0] chg_len;

    always #5 clk = ~clk;

    fwd_clk_burst_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_div   (cfg_div),
        .cfg_cont  (cfg_cont),
        .burst_req (burst_req),
        .burst_len (burst_len),
        .abort     (abort),
        .burst_ack (burst_ack),
        .busy      (busy),
        .done      (done),
        .fwd_clk_o (fwd_clk_o),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .edge_cnt  (edge_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after an edge; that interval is cycle 0 and burst_req is raised in it.
    task automatic run(input int n);
        cap_fw = '0; cap_ri = '0; cap_fa = '0; cap_ack = '0; cap_busy = '0; cap_done = '0;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            cap_fw[i]   = fwd_clk_o;
            cap_ri[i]   = rise_stb;
            cap_fa[i]   = fall_stb;
            cap_ack[i]  = burst_ack;
            cap_busy[i] = busy;
            cap_done[i] = done;
            if (i == 0) burst_req = 1'b1;
            if (i == rel_at) burst_req = 1'b0;
            if (i == abort_at) abort = 1'b1;
            if (i == chg_at) begin
                cfg_div   = chg_div;
                burst_len = chg_len;
            end
        end
        abort = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_div = 8'd0; cfg_cont = 1'b0; burst_req = 1'b0;
        burst_len = 16'd0; abort = 1'b0;
        rel_at = 1; abort_at = -1; chg_at = -1; chg_div = 8'd0; chg_len = 16'd0;
        #12;
        chk("reset_fwd_clk", {31'd0, fwd_clk_o}, 32'd0);
        chk("reset_busy",    {31'd0, busy},      32'd0);
        chk("reset_ack",     {31'd0, burst_ack}, 32'd0);
        chk("reset_done",    {31'd0, done},      32'd0);
        chk("reset_rise",    {31'd0, rise_stb},  32'd0);
        chk("reset_fall",    {31'd0, fall_stb},  32'd0);
        chk("reset_edge_cnt", {16'd0, edge_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // div=2 len=3
        cfg_div = 8'd2; burst_len = 16'd3;
        run(18);
        chk("t1_ack",  cap_ack,  32'h0000_0002);
        chk("t1_fwd",  cap_fw,   32'h0000_1998);
        chk("t1_rise", cap_ri,   32'h0000_0888);
        chk("t1_fall", cap_fa,   32'h0000_2220);
        chk("t1_busy", cap_busy, 32'h0001_FFFE);
        chk("t1_done", cap_done, 32'h0002_0000);
        chk("t1_edge_cnt", {16'd0, edge_cnt}, 32'd3);

        // div=0 behaves as D=1
        cfg_div = 8'd0; burst_len = 16'd1;
        run(6);
        chk("t2_fwd",  cap_fw,   32'h0000_0004);
        chk("t2_busy", cap_busy, 32'h0000_001E);
        chk("t2_done", cap_done, 32'h0000_0020);
        chk("t2_edge_cnt", {16'd0, edge_cnt}, 32'd1);

        // len=0: lead and trail only
        cfg_div = 8'd3; burst_len = 16'd0;
        run(8);
        chk("t3_fwd",  cap_fw,   32'h0000_0000);
        chk("t3_busy", cap_busy, 32'h0000_007E);
        chk("t3_done", cap_done, 32'h0000_0080);
        chk("t3_edge_cnt", {16'd0, edge_cnt}, 32'd0);

        // continuous, D=1, abort raised during the 4th high phase
        cfg_div = 8'd1; cfg_cont = 1'b1; burst_len = 16'd0; abort_at = 8;
        run(12);
        abort_at = -1; cfg_cont = 1'b0;
        chk("t4_fwd",  cap_fw,   32'h0000_0154);
        chk("t4_rise", cap_ri,   32'h0000_0154);
        chk("t4_fall", cap_fa,   32'h0000_02A8);
        chk("t4_busy", cap_busy, 32'h0000_07FE);
        chk("t4_done", cap_done, 32'h0000_0800);
        chk("t4_edge_cnt", {16'd0, edge_cnt}, 32'd4);

        // req held through done; config changed mid-burst
        cfg_div = 8'd1; burst_len = 16'd2;
        rel_at = 19; chg_at = 2; chg_div = 8'd3; chg_len = 16'd1;
        run(21);
        rel_at = 1; chg_at = -1;
        chk("t5_ack",  cap_ack,  32'h0000_0102);
        chk("t5_fwd",  cap_fw,   32'h0000_3814);
        chk("t5_rise", cap_ri,   32'h0000_0814);
        chk("t5_busy", cap_busy, 32'h000F_FF7E);
        chk("t5_done", cap_done, 32'h0010_0080);
        chk("t5_edge_cnt", {16'd0, edge_cnt}, 32'd1);

        // async reset in the middle of the first high phase
        cfg_div = 8'd2; burst_len = 16'd3;
        run(3);
        chk("t6_fwd_before", cap_fw, 32'h0000_0008);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_fwd_async",  {31'd0, fwd_clk_o}, 32'd0);
        chk("t6_busy_async", {31'd0, busy},      32'd0);
        chk("t6_edge_cnt_async", {16'd0, edge_cnt}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            acc[i] = done | busy | fwd_clk_o;
        end
        chk("t6_quiet_after_reset", acc, 32'd0);
        run(18);
        chk("t6_fwd_fresh",  cap_fw,   32'h0000_1998);
        chk("t6_done_fresh", cap_done, 32'h0002_0000);
        chk("t6_edge_cnt_fresh", {16'd0, edge_cnt}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
